// File: rtl/eth_rx_pkg.sv
// Shared definitions for the MII receive sequencer: one-hot phase
// encoding, preamble/SFD nibble values and the phase-to-strobe decode.
package eth_rx_pkg;

    localparam int STATE_W      = 9;

    localparam int IDX_IDLE     = 0;
    localparam int IDX_PREAMBLE = 1;
    localparam int IDX_SFD      = 2;
    localparam int IDX_DA       = 3;
    localparam int IDX_SA       = 4;
    localparam int IDX_LENGTH   = 5;
    localparam int IDX_DATA0    = 6;
    localparam int IDX_DATA1    = 7;
    localparam int IDX_DROP     = 8;

    // Bit positions inside the two-bit StateData strobe
    localparam int DATA_LO_BIT  = 0;
    localparam int DATA_HI_BIT  = 1;

    localparam logic [3:0] NIB_PREAMBLE = 4'h5;
    localparam logic [3:0] NIB_SFD      = 4'hD;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 9'b1 << IDX_IDLE,
        ST_PREAMBLE = 9'b1 << IDX_PREAMBLE,
        ST_SFD      = 9'b1 << IDX_SFD,
        ST_DA       = 9'b1 << IDX_DA,
        ST_SA       = 9'b1 << IDX_SA,
        ST_LENGTH   = 9'b1 << IDX_LENGTH,
        ST_DATA0    = 9'b1 << IDX_DATA0,
        ST_DATA1    = 9'b1 << IDX_DATA1,
        ST_DROP     = 9'b1 << IDX_DROP
    } rxState_t;

    typedef struct packed {
        logic       idle;
        logic       preamble;
        logic       sfd;
        logic       da;
        logic       sa;
        logic       length;
        logic [1:0] data;
        logic       drop;
    } rxStrobes_t;

    // The state register is already one-hot, so each strobe is one bit of it
    function automatic rxStrobes_t decodeStrobes(input rxState_t st);
        rxStrobes_t s;
        s.idle     = st[IDX_IDLE];
        s.preamble = st[IDX_PREAMBLE];
        s.sfd      = st[IDX_SFD];
        s.da       = st[IDX_DA];
        s.sa       = st[IDX_SA];
        s.length   = st[IDX_LENGTH];
        s.data     = {st[IDX_DATA1], st[IDX_DATA0]};
        s.drop     = st[IDX_DROP];
        return s;
    endfunction

endpackage

// File: rtl/eth_rx_byteasm.sv
// Nibble-to-byte assembler for the receive data phase. The low nibble is
// held while the sequencer is in DATA0; the byte is completed and flagged
// valid when the high nibble arrives in DATA1. A low nibble left over at
// end of frame never reaches RxData.
module eth_rx_byteasm
    import eth_rx_pkg::*;
(
    input  logic       MRxClk,
    input  logic       Reset,
    input  logic       MRxDV,
    input  logic [3:0] MRxD,
    input  logic [1:0] StateData,
    output logic [7:0] RxData,
    output logic       RxValid,
    output logic       RxStartFrm
);

    logic [3:0] lowNib_p0;
    logic       firstByte;

    logic lowNibEn;
    logic byteDone;

    assign lowNibEn = StateData[DATA_LO_BIT] & MRxDV;
    assign byteDone = StateData[DATA_HI_BIT] & MRxDV;

    // Latch nibbles, emit the byte one cycle after its high nibble, and
    // mark the first byte of each data phase with RxStartFrm
    always_ff @(posedge MRxClk or posedge Reset) begin
        if (Reset) begin
            lowNib_p0  <= 4'h0;
            RxData     <= 8'h00;
            RxValid    <= 1'b0;
            RxStartFrm <= 1'b0;
            firstByte  <= 1'b1;
        end else begin
            RxValid    <= byteDone;
            RxStartFrm <= byteDone & firstByte;
            if (lowNibEn) begin
                lowNib_p0 <= MRxD;
            end
            if (byteDone) begin
                RxData <= {MRxD, lowNib_p0};
            end
            // Re-arm outside the data phase (IDLE, DROP, or the header)
            if (StateData == 2'b00) begin
                firstByte <= 1'b1;
            end else if (byteDone) begin
                firstByte <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/eth_rxsequencer.sv
// MII receive frame sequencer. Walks each nibble stream through preamble,
// SFD, address, length/type and data phases, drives the one-hot phase
// strobes for the receive counter block and reports frame start, end,
// abort and oversize events.
module eth_rxsequencer
    import eth_rx_pkg::*;
#(
    parameter bit IFG_CHECK = 1'b1
) (
    input  logic       MRxClk,
    input  logic       Reset,
    input  logic       MRxDV,
    input  logic [3:0] MRxD,
    input  logic       Transmitting,
    input  logic       IFGCounterEq24,
    input  logic       ByteCntEq1,
    input  logic       ByteCntEq5,
    input  logic       ByteCntMaxFrame,
    input  logic       Rx_NibCnt,
    output logic       StateIdle,
    output logic       StatePreamble,
    output logic       StateSFD,
    output logic       StateDA,
    output logic       StateSA,
    output logic       StateLength,
    output logic [1:0] StateData,
    output logic       StateDrop,
    output logic       MRxDEq5,
    output logic       MRxDEqD,
    output logic [7:0] RxData,
    output logic       RxValid,
    output logic       RxStartFrm,
    output logic       RxEndFrm,
    output logic       RxAbort,
    output logic       RxTooLong
);

    rxState_t   state;
    rxStrobes_t strobes;
    logic       ifgOk;

    assign MRxDEq5 = (MRxD == NIB_PREAMBLE);
    assign MRxDEqD = (MRxD == NIB_SFD);

    // With the gap check disabled an SFD is accepted regardless of the IFG flag
    assign ifgOk = IFGCounterEq24 | ~IFG_CHECK;

    // Phase register plus the status pulses that accompany its transitions
    always_ff @(posedge MRxClk or posedge Reset) begin
        if (Reset) begin
            state     <= ST_DROP;
            RxEndFrm  <= 1'b0;
            RxAbort   <= 1'b0;
            RxTooLong <= 1'b0;
        end else begin
            RxEndFrm  <= 1'b0;
            RxAbort   <= 1'b0;
            RxTooLong <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (MRxDV & (Transmitting | ~MRxDEq5)) begin
                        state <= ST_DROP;
                    end else if (MRxDV & MRxDEq5) begin
                        state <= ST_PREAMBLE;
                    end
                end
                ST_PREAMBLE: begin
                    if (~MRxDV) begin
                        state <= ST_IDLE;
                    end else if (MRxDEqD & ifgOk) begin
                        state <= ST_SFD;
                    end else if (MRxDEqD | ~MRxDEq5) begin
                        state <= ST_DROP;
                    end
                end
                ST_SFD: begin
                    if (~MRxDV) begin
                        state   <= ST_IDLE;
                        RxAbort <= 1'b1;
                    end else if (ByteCntEq1) begin
                        state <= ST_DA;
                    end
                end
                ST_DA: begin
                    if (~MRxDV) begin
                        state   <= ST_IDLE;
                        RxAbort <= 1'b1;
                    end else if (ByteCntEq5 & Rx_NibCnt) begin
                        state <= ST_SA;
                    end
                end
                ST_SA: begin
                    if (~MRxDV) begin
                        state   <= ST_IDLE;
                        RxAbort <= 1'b1;
                    end else if (ByteCntEq5 & Rx_NibCnt) begin
                        state <= ST_LENGTH;
                    end
                end
                ST_LENGTH: begin
                    if (~MRxDV) begin
                        state   <= ST_IDLE;
                        RxAbort <= 1'b1;
                    end else if (ByteCntEq1 & Rx_NibCnt) begin
                        state <= ST_DATA0;
                    end
                end
                ST_DATA0: begin
                    if (~MRxDV) begin
                        state    <= ST_IDLE;
                        RxEndFrm <= 1'b1;
                    end else begin
                        state <= ST_DATA1;
                    end
                end
                ST_DATA1: begin
                    // End of frame takes precedence over the length limit
                    if (~MRxDV) begin
                        state    <= ST_IDLE;
                        RxEndFrm <= 1'b1;
                    end else if (ByteCntMaxFrame) begin
                        state     <= ST_DROP;
                        RxTooLong <= 1'b1;
                    end else begin
                        state <= ST_DATA0;
                    end
                end
                ST_DROP: begin
                    if (~MRxDV & IFGCounterEq24) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_DROP;
                end
            endcase
        end
    end

    assign strobes       = decodeStrobes(state);
    assign StateIdle     = strobes.idle;
    assign StatePreamble = strobes.preamble;
    assign StateSFD      = strobes.sfd;
    assign StateDA       = strobes.da;
    assign StateSA       = strobes.sa;
    assign StateLength   = strobes.length;
    assign StateData     = strobes.data;
    assign StateDrop     = strobes.drop;

    eth_rx_byteasm u_byteasm (
        .MRxClk     (MRxClk),
        .Reset      (Reset),
        .MRxDV      (MRxDV),
        .MRxD       (MRxD),
        .StateData  (StateData),
        .RxData     (RxData),
        .RxValid    (RxValid),
        .RxStartFrm (RxStartFrm)
    );

endmodule

// File: tb/tb_eth_rxsequencer.sv
// Bench for eth_rxsequencer: reset state, nibble decodes, a cycle table for
// the drop/idle paths, hand-built frames for the multi-cycle corners and
// randomized frames checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_eth_rxsequencer;

    logic       MRxClk = 1'b0;
    logic       Reset;
    logic       MRxDV;
    logic [3:0] MRxD;
    logic       Transmitting, IFGCounterEq24, ByteCntEq1, ByteCntEq5, ByteCntMaxFrame, Rx_NibCnt;
    logic       StateIdle, StatePreamble, StateSFD, StateDA, StateSA, StateLength, StateDrop;
    logic [1:0] StateData;
    logic       MRxDEq5, MRxDEqD;
    logic [7:0] RxData;
    logic       RxValid, RxStartFrm, RxEndFrm, RxAbort, RxTooLong;

    eth_rxsequencer #(.IFG_CHECK(1'b1)) dut (
        .MRxClk(MRxClk), .Reset(Reset), .MRxDV(MRxDV), .MRxD(MRxD),
        .Transmitting(Transmitting), .IFGCounterEq24(IFGCounterEq24),
        .ByteCntEq1(ByteCntEq1), .ByteCntEq5(ByteCntEq5),
        .ByteCntMaxFrame(ByteCntMaxFrame), .Rx_NibCnt(Rx_NibCnt),
        .StateIdle(StateIdle), .StatePreamble(StatePreamble), .StateSFD(StateSFD),
        .StateDA(StateDA), .StateSA(StateSA), .StateLength(StateLength),
        .StateData(StateData), .StateDrop(StateDrop),
        .MRxDEq5(MRxDEq5), .MRxDEqD(MRxDEqD),
        .RxData(RxData), .RxValid(RxValid), .RxStartFrm(RxStartFrm),
        .RxEndFrm(RxEndFrm), .RxAbort(RxAbort), .RxTooLong(RxTooLong)
    );

    always #5 MRxClk = ~MRxClk;

    // Strobe vector {Idle,Preamble,SFD,DA,SA,Length,Data[1],Data[0],Drop}
    localparam logic [8:0] S_IDLE = 9'b100000000;
    localparam logic [8:0] S_PRE  = 9'b010000000;
    localparam logic [8:0] S_SFD  = 9'b001000000;
    localparam logic [8:0] S_DROP = 9'b000000001;
    // Pulse vector {RxValid,RxStartFrm,RxEndFrm,RxAbort,RxTooLong}
    localparam logic [4:0] P_NONE  = 5'b00000;
    localparam logic [4:0] P_ABORT = 5'b00010;

    logic [8:0] stVec;
    logic [4:0] plVec;
    assign stVec = {StateIdle, StatePreamble, StateSFD, StateDA, StateSA, StateLength, StateData, StateDrop};
    assign plVec = {RxValid, RxStartFrm, RxEndFrm, RxAbort, RxTooLong};

    typedef struct packed {
        logic       dv;
        logic [3:0] d;
        logic       ifg;
        logic       tx;
        logic [8:0] st;
        logic [4:0] pl;
    } vec_t;

    vec_t tbl [19];

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    logic [7:0] gotBytes[$];
    logic [7:0] expBytes[$];
    int   nStart, nEnd, nAbort, nTooLong, oneHotErr, fallCyc, endCyc, abortCyc;
    logic startOnFirst, abortIdle, tooLongDrop;
    logic eEnd, eAbort, eTooLong;
    logic [3:0] datN [32];
    logic [3:0] badNib;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic vec_t mkv(input logic dv, input logic [3:0] d, input logic ifg,
                                 input logic tx, input logic [8:0] st, input logic [4:0] pl);
        vec_t v;
        v.dv = dv; v.d = d; v.ifg = ifg; v.tx = tx; v.st = st; v.pl = pl;
        return v;
    endfunction

    task automatic clearAcc();
        gotBytes.delete();
        nStart = 0; nEnd = 0; nAbort = 0; nTooLong = 0; oneHotErr = 0;
        fallCyc = -1; endCyc = -2; abortCyc = -2;
        startOnFirst = 1'b0; abortIdle = 1'b0; tooLongDrop = 1'b0;
    endtask

    // Drive one nibble period, then sample just after the clock edge
    task automatic step(input logic dv, input logic [3:0] d, input logic ifg, input logic tx,
                        input logic b1, input logic b5, input logic mx, input logic nib);
        MRxDV = dv; MRxD = d; IFGCounterEq24 = ifg; Transmitting = tx;
        ByteCntEq1 = b1; ByteCntEq5 = b5; ByteCntMaxFrame = mx; Rx_NibCnt = nib;
        @(posedge MRxClk);
        #1;
        cyc++;
        if ($countones(stVec) != 1) oneHotErr++;
        if (RxValid) begin
            if (gotBytes.size() == 0 && RxStartFrm) startOnFirst = 1'b1;
            gotBytes.push_back(RxData);
        end
        if (RxStartFrm) nStart++;
        if (RxEndFrm) begin nEnd++; endCyc = cyc; end
        if (RxAbort) begin nAbort++; abortCyc = cyc; abortIdle = StateIdle; end
        if (RxTooLong) begin nTooLong++; tooLongDrop = StateDrop; end
    endtask

    // Frame-level reference: which bytes a frame yields and how it ends
    task automatic predict(input int preLen, input int badPreAt, input logic tx, input logic ifgOk,
                           input int abortAt, input int dataNibs, input int maxAt, input int rstAt);
        int last;
        expBytes.delete();
        eEnd = 1'b0; eAbort = 1'b0; eTooLong = 1'b0;
        if (tx || (badPreAt >= 0 && badPreAt < preLen) || !ifgOk) return;
        if (abortAt >= 0 && abortAt < 29) begin eAbort = 1'b1; return; end
        last = dataNibs;
        if (rstAt >= 0 && rstAt < dataNibs) last = rstAt;
        else if (maxAt >= 0 && maxAt < dataNibs && (maxAt % 2) == 1) begin
            last = maxAt + 1;
            eTooLong = 1'b1;
        end else eEnd = 1'b1;
        for (int b = 0; b + 1 < last; b += 2) expBytes.push_back({datN[b+1], datN[b]});
    endtask

    // Frame layout after the preamble: D nibble, one SFD-phase nibble
    // (header index 0), 12 DA, 12 SA, 4 length nibbles, then data
    task automatic sendFrame(input int preLen, input int badPreAt, input logic tx, input logic ifgOk,
                             input int abortAt, input int dataNibs, input int maxAt, input int rstAt);
        logic aborted, b1, b5, nib;
        int k;
        clearAcc();
        aborted = 1'b0;
        for (int i = 0; i < preLen; i++)
            step(1'b1, (i == badPreAt) ? badNib : 4'h5, ifgOk, tx, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'hD, ifgOk, tx, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int h = 0; h < 29 && !aborted; h++) begin
            if (h == abortAt) aborted = 1'b1;
            else begin
                k   = (h <= 12) ? h - 1 : (h <= 24) ? h - 13 : h - 25;
                b1  = (h == 0) || (h >= 25 && k >= 2);
                b5  = (h >= 1 && h <= 24 && k >= 10);
                nib = (h >= 1) && k[0];
                step(1'b1, 4'($urandom_range(0, 15)), ifgOk, 1'b0, b1, b5, 1'b0, nib);
            end
        end
        if (!aborted) begin
            for (int j = 0; j < dataNibs; j++) begin
                if (j == rstAt) begin
                    chk("rst_pre_data1", 32'(StateData), 32'(2'b10));
                    #2 Reset = 1'b1;
                    #1;
                    chk("rst_mid_strobes", 32'(stVec), 32'(S_DROP));
                    chk("rst_mid_pulses", 32'(plVec), 32'(P_NONE));
                    chk("rst_mid_rxdata", 32'(RxData), 32'd0);
                    Reset = 1'b0;
                end
                step(1'b1, datN[j], ifgOk, 1'b0, 1'b0, 1'b0, (j == maxAt), (j % 2 == 1));
            end
        end
        fallCyc = cyc + 1;
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, (maxAt == dataNibs && !aborted), 1'b0);
        repeat (2) step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkFrame(input string tag);
        logic hasBytes;
        hasBytes = (expBytes.size() > 0);
        chk({tag, "_nbytes"}, 32'(gotBytes.size()), 32'(expBytes.size()));
        for (int i = 0; i < expBytes.size() && i < gotBytes.size(); i++)
            chk({tag, "_byte"}, 32'(gotBytes[i]), 32'(expBytes[i]));
        chk({tag, "_start_n"}, 32'(nStart), 32'(hasBytes));
        chk({tag, "_start_first"}, 32'(startOnFirst), 32'(hasBytes));
        chk({tag, "_end"}, 32'(nEnd), 32'(eEnd));
        chk({tag, "_abort"}, 32'(nAbort), 32'(eAbort));
        chk({tag, "_toolong"}, 32'(nTooLong), 32'(eTooLong));
        chk({tag, "_idle_after"}, 32'(StateIdle), 32'd1);
        chk({tag, "_onehot_err"}, 32'(oneHotErr), 32'd0);
    endtask

    task automatic runFrame(input string tag, input int preLen, input int badPreAt, input logic tx,
                            input logic ifgOk, input int abortAt, input int dataNibs,
                            input int maxAt, input int rstAt);
        sendFrame(preLen, badPreAt, tx, ifgOk, abortAt, dataNibs, maxAt, rstAt);
        predict(preLen, badPreAt, tx, ifgOk, abortAt, dataNibs, maxAt, rstAt);
        checkFrame(tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, preLen, badPreAt, abortAt, dataNibs, maxAt;
        logic tx, ifgOk;

        Reset = 1'b1; MRxDV = 1'b0; MRxD = 4'h0; Transmitting = 1'b0; IFGCounterEq24 = 1'b0;
        ByteCntEq1 = 1'b0; ByteCntEq5 = 1'b0; ByteCntMaxFrame = 1'b0; Rx_NibCnt = 1'b0;
        badNib = 4'h3;
        clearAcc();

        repeat (2) @(posedge MRxClk);
        #1;
        chk("reset_strobes", 32'(stVec), 32'(S_DROP));
        chk("reset_pulses", 32'(plVec), 32'(P_NONE));
        chk("reset_rxdata", 32'(RxData), 32'd0);
        Reset = 1'b0;

        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("drop_to_idle", 32'(stVec), 32'(S_IDLE));

        // Combinational nibble decodes
        for (int n = 0; n < 16; n++) begin
            step(1'b0, 4'(n), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("decode_%0h", n), 32'({MRxDEq5, MRxDEqD}),
                32'({(n == 5), (n == 13)}));
        end

        // Cycle table: bad preamble, transmitter busy, IFG too short,
        // MRxDV loss in preamble, MRxDV loss in SFD
        tbl[0]  = mkv(1'b1, 4'h5, 1'b1, 1'b0, S_PRE,  P_NONE);
        tbl[1]  = mkv(1'b1, 4'h5, 1'b1, 1'b0, S_PRE,  P_NONE);
        tbl[2]  = mkv(1'b1, 4'h3, 1'b1, 1'b0, S_DROP, P_NONE);
        tbl[3]  = mkv(1'b1, 4'h5, 1'b1, 1'b0, S_DROP, P_NONE);
        tbl[4]  = mkv(1'b0, 4'h0, 1'b1, 1'b0, S_IDLE, P_NONE);
        tbl[5]  = mkv(1'b1, 4'h5, 1'b1, 1'b1, S_DROP, P_NONE);
        tbl[6]  = mkv(1'b1, 4'h5, 1'b1, 1'b1, S_DROP, P_NONE);
        tbl[7]  = mkv(1'b0, 4'h0, 1'b0, 1'b0, S_DROP, P_NONE);
        tbl[8]  = mkv(1'b0, 4'h0, 1'b1, 1'b0, S_IDLE, P_NONE);
        tbl[9]  = mkv(1'b1, 4'h5, 1'b0, 1'b0, S_PRE,  P_NONE);
        tbl[10] = mkv(1'b1, 4'h5, 1'b0, 1'b0, S_PRE,  P_NONE);
        tbl[11] = mkv(1'b1, 4'hD, 1'b0, 1'b0, S_DROP, P_NONE);
        tbl[12] = mkv(1'b0, 4'h0, 1'b1, 1'b0, S_IDLE, P_NONE);
        tbl[13] = mkv(1'b1, 4'h5, 1'b1, 1'b0, S_PRE,  P_NONE);
        tbl[14] = mkv(1'b0, 4'h0, 1'b1, 1'b0, S_IDLE, P_NONE);
        tbl[15] = mkv(1'b1, 4'h5, 1'b1, 1'b0, S_PRE,  P_NONE);
        tbl[16] = mkv(1'b1, 4'hD, 1'b1, 1'b0, S_SFD,  P_NONE);
        tbl[17] = mkv(1'b0, 4'h0, 1'b1, 1'b0, S_IDLE, P_ABORT);
        tbl[18] = mkv(1'b0, 4'h0, 1'b1, 1'b0, S_IDLE, P_NONE);
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].dv, tbl[i].d, tbl[i].ifg, tbl[i].tx, 1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("vec%0d_state", i), 32'(stVec), 32'(tbl[i].st));
            chk($sformatf("vec%0d_pulses", i), 32'(plVec), 32'(tbl[i].pl));
        end

        // Legal frame, data nibbles 1..8 -> bytes 21 43 65 87
        for (int j = 0; j < 32; j++) datN[j] = 4'(j + 1);
        runFrame("legal", 14, -1, 1'b0, 1'b1, -1, 8, -1, -1);
        chk("legal_byte0_const", 32'(gotBytes.size() > 0 ? gotBytes[0] : 8'h00), 32'h21);
        chk("legal_byte3_const", 32'(gotBytes.size() > 3 ? gotBytes[3] : 8'h00), 32'h87);
        chk("legal_end_cycle", 32'(endCyc), 32'(fallCyc));

        // MRxDV lost on the 6th SA nibble
        runFrame("abort_sa6", 14, -1, 1'b0, 1'b1, 18, 8, -1, -1);
        chk("abort_cycle", 32'(abortCyc), 32'(fallCyc));
        chk("abort_idle", 32'(abortIdle), 32'd1);

        // Length limit hit in DATA1
        runFrame("toolong", 14, -1, 1'b0, 1'b1, -1, 10, 5, -1);
        chk("toolong_drop", 32'(tooLongDrop), 32'd1);

        // Length limit on the same edge MRxDV falls in DATA1
        runFrame("max_and_end", 8, -1, 1'b0, 1'b1, -1, 5, 5, -1);

        // Odd nibble count: trailing nibble discarded
        runFrame("dangling", 8, -1, 1'b0, 1'b1, -1, 7, -1, -1);

        // Asynchronous reset during DATA1
        runFrame("rst_data1", 8, -1, 1'b0, 1'b1, -1, 8, -1, 3);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            kind     = int'($urandom_range(0, 5));
            preLen   = int'($urandom_range(1, 15));
            dataNibs = int'($urandom_range(0, 20));
            badPreAt = -1; tx = 1'b0; ifgOk = 1'b1; abortAt = -1; maxAt = -1;
            for (int j = 0; j < 32; j++) datN[j] = 4'($urandom_range(0, 15));
            do badNib = 4'($urandom_range(0, 15)); while (badNib == 4'h5 || badNib == 4'hD);
            case (kind)
                1: badPreAt = int'($urandom_range(0, preLen - 1));
                2: tx = 1'b1;
                3: ifgOk = 1'b0;
                4: abortAt = int'($urandom_range(0, 28));
                5: begin
                    if (dataNibs < 2) dataNibs = 6;
                    maxAt = 2 * int'($urandom_range(0, (dataNibs - 2) / 2)) + 1;
                end
                default: ;
            endcase
            runFrame($sformatf("rand%0d", f), preLen, badPreAt, tx, ifgOk, abortAt, dataNibs, maxAt, -1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
